// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, frame
// deserialiser with parity/framing/timeout checks, and a show-ahead FIFO
// feeding registered data and status bytes for the CPU input mux.
module ps2_kbd_rx #(
  parameter int unsigned FILT_LEN    = 128,
  parameter int unsigned TIMEOUT_CYC = 250000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       pll0_250MHz,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic       ps2DIn_cs,
  input  logic       ps2StIn_cs,
  output logic [7:0] ps2kybdData,
  output logic [7:0] ps2StatInp
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxState_e;

  logic          clkS1, clkS2, dataS1, dataS2;
  logic          filtClk, fallStb;
  logic [FW-1:0] filtCnt;

  rxState_e      rxState;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg, pushByte;
  logic          parBit, pushReq;
  logic [TW-1:0] toCnt;
  logic          perrSet, ferrSet, toerrSet;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          dinPrev, stPrev;
  logic          perr, ferr, ovr, toerr;

  logic popStb, clrStb, fifoEmpty, fifoFull, doPop, doWrite, ovrSet;

  always_comb begin
    popStb    = dinPrev & ~ps2DIn_cs;
    clrStb    = stPrev & ~ps2StIn_cs;
    fifoEmpty = (count == '0);
    fifoFull  = (count == CW'(FIFO_DEPTH));
    doPop     = popStb & ~fifoEmpty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    doWrite   = pushReq & (~fifoFull | doPop);
    ovrSet    = pushReq & fifoFull & ~doPop;
  end

  // two-stage synchronisers for the asynchronous pins, plus CPU select history
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      clkS1   <= 1'b1;
      clkS2   <= 1'b1;
      dataS1  <= 1'b1;
      dataS2  <= 1'b1;
      dinPrev <= 1'b0;
      stPrev  <= 1'b0;
    end else begin
      clkS1   <= ps2Clk;
      clkS2   <= clkS1;
      dataS1  <= ps2Data;
      dataS2  <= dataS1;
      dinPrev <= ps2DIn_cs;
      stPrev  <= ps2StIn_cs;
    end
  end

  // glitch filter: adopt a new clock level only after it holds FILT_LEN cycles
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      filtClk <= 1'b1;
      filtCnt <= '0;
      fallStb <= 1'b0;
    end else begin
      fallStb <= 1'b0;
      if (clkS2 == filtClk) begin
        filtCnt <= '0;
      end else if (filtCnt == FW'(FILT_LEN - 1)) begin
        filtClk <= clkS2;
        filtCnt <= '0;
        fallStb <= filtClk;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
    end
  end

  // frame deserialiser with inter-edge timeout; emits one-cycle push/error pulses
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      rxState  <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      parBit   <= 1'b0;
      toCnt    <= '0;
      pushReq  <= 1'b0;
      pushByte <= '0;
      perrSet  <= 1'b0;
      ferrSet  <= 1'b0;
      toerrSet <= 1'b0;
    end else begin
      pushReq  <= 1'b0;
      perrSet  <= 1'b0;
      ferrSet  <= 1'b0;
      toerrSet <= 1'b0;
      if (rxState == IDLE) begin
        toCnt <= '0;
        if (fallStb && !dataS2) begin
          rxState <= DATA;
          bitCnt  <= '0;
        end
      end else if (fallStb) begin
        toCnt <= '0;
        case (rxState)
          DATA: begin
            shiftReg <= {dataS2, shiftReg[7:1]};
            bitCnt   <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) rxState <= PARITY;
          end
          PARITY: begin
            parBit  <= dataS2;
            rxState <= STOP;
          end
          STOP: begin
            rxState <= IDLE;
            if (!dataS2) begin
              ferrSet <= 1'b1;
            end else if (^{shiftReg, parBit}) begin
              pushReq  <= 1'b1;
              pushByte <= shiftReg;
            end else begin
              perrSet <= 1'b1;
            end
          end
          default: rxState <= IDLE;
        endcase
      end else if (toCnt == TW'(TIMEOUT_CYC - 1)) begin
        toerrSet <= 1'b1;
        toCnt    <= '0;
        rxState  <= IDLE;
      end else begin
        toCnt <= toCnt + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because reads are gated by count
  always_ff @(posedge pll0_250MHz) begin
    if (doWrite) mem[wrPtr] <= pushByte;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doPop)   rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sticky error flags; a set in the clearing cycle survives the clear
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      toerr <= 1'b0;
    end else begin
      perr  <= perrSet  | (perr  & ~clrStb);
      ferr  <= ferrSet  | (ferr  & ~clrStb);
      ovr   <= ovrSet   | (ovr   & ~clrStb);
      toerr <= toerrSet | (toerr & ~clrStb);
    end
  end

  // registered CPU-facing data and status bytes
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      ps2kybdData <= '0;
      ps2StatInp  <= '0;
    end else begin
      ps2kybdData <= fifoEmpty ? 8'h00 : mem[rdPtr];
      ps2StatInp  <= {2'b00, toerr, ovr, ferr, perr, fifoFull, ~fifoEmpty};
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx with scaled-down filter/timeout parameters.
module tb_ps2_kbd_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TO   = 600;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       ps2DIn_cs = 1'b0;
  logic       ps2StIn_cs = 1'b0;
  logic [7:0] ps2kybdData;
  logic [7:0] ps2StatInp;

  int nVec = 0;
  int nErr = 0;

  ps2_kbd_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO), .FIFO_DEPTH(8)) dut (
    .pll0_250MHz(clk),
    .reset(reset),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .ps2DIn_cs(ps2DIn_cs),
    .ps2StIn_cs(ps2StIn_cs),
    .ps2kybdData(ps2kybdData),
    .ps2StatInp(ps2StatInp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         parFlip;
    bit         stopVal;
    logic [7:0] expD;
    logic [7:0] expS;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one PS/2 bit: data set while clock high, device drops clock for half a period
  task automatic sendBit(input logic b, input bit glitch);
    ps2Data = b;
    if (glitch) begin
      cyc(10);
      ps2Clk = 1'b0;
      cyc(3);
      ps2Clk = 1'b1;
      cyc(HALF - 13);
    end else begin
      cyc(HALF);
    end
    ps2Clk = 1'b0;
    cyc(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit parFlip, input bit stopVal, input bit glitch);
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i], glitch);
    sendBit((~^d) ^ parFlip, glitch);
    sendBit(stopVal, 1'b0);
    ps2Data = 1'b1;
    cyc(20);
  endtask

  task automatic popRead();
    ps2DIn_cs = 1'b1;
    cyc(20);
    ps2DIn_cs = 1'b0;
    cyc(4);
  endtask

  task automatic clearFlags();
    ps2StIn_cs = 1'b1;
    cyc(5);
    ps2StIn_cs = 1'b0;
    cyc(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 8'h01};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 8'h00, 8'h04};
    vecs[2] = '{8'hE7, 1'b0, 1'b1, 8'hE7, 8'h01};
    vecs[3] = '{8'h33, 1'b0, 1'b0, 8'h00, 8'h08};
    vecs[4] = '{8'h33, 1'b1, 1'b0, 8'h00, 8'h08};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 8'h01};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 8'h01};

    cyc(5);
    check("reset_data", ps2kybdData, 8'h00);
    check("reset_stat", ps2StatInp, 8'h00);
    reset = 1'b0;
    cyc(20);
    check("idle_stat", ps2StatInp, 8'h00);

    // table: one frame, check, then pop (possibly empty) and clear flags
    for (int i = 0; i < 7; i++) begin
      sendFrame(vecs[i].d, vecs[i].parFlip, vecs[i].stopVal, 1'b0);
      check($sformatf("vec%0d_data", i), ps2kybdData, vecs[i].expD);
      check($sformatf("vec%0d_stat", i), ps2StatInp, vecs[i].expS);
      popRead();
      check($sformatf("vec%0d_popstat", i), ps2StatInp, vecs[i].expS & 8'hFC);
      clearFlags();
      check($sformatf("vec%0d_clrdata", i), ps2kybdData, 8'h00);
      check($sformatf("vec%0d_clrstat", i), ps2StatInp, 8'h00);
    end

    // overflow: nine frames into eight slots
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0, 1'b1, 1'b0);
    check("ovr_stat", ps2StatInp, 8'h13);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovr_pop%0d", i), ps2kybdData, 8'(i));
      popRead();
    end
    check("ovr_empty_data", ps2kybdData, 8'h00);
    check("ovr_empty_stat", ps2StatInp, 8'h10);
    clearFlags();
    check("ovr_clr_stat", ps2StatInp, 8'h00);

    // timeout after start + 3 data bits
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    ps2Data = 1'b1;
    cyc(TO + 100);
    check("to_stat", ps2StatInp, 8'h20);
    check("to_data", ps2kybdData, 8'h00);
    sendFrame(8'hF0, 1'b0, 1'b1, 1'b0);
    check("to_next_data", ps2kybdData, 8'hF0);
    check("to_next_stat", ps2StatInp, 8'h21);
    popRead();
    clearFlags();
    check("to_clr_stat", ps2StatInp, 8'h00);

    // short low glitches on the PS/2 clock during data bits
    sendFrame(8'h6B, 1'b0, 1'b1, 1'b1);
    check("glitch_data", ps2kybdData, 8'h6B);
    check("glitch_stat", ps2StatInp, 8'h01);
    popRead();
    check("glitch_empty", ps2StatInp, 8'h00);

    // full FIFO; final push coincides with a data-port falling edge
    for (int i = 0; i < 8; i++) sendFrame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
    check("full_stat", ps2StatInp, 8'h03);
    ps2DIn_cs = 1'b1;
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(((8'h19 >> i) & 8'h01) != 0, 1'b0);
    sendBit(1'b0, 1'b0);
    ps2Data = 1'b1;
    cyc(HALF);
    ps2Clk = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cyc(1);
      if (dut.pushReq) begin
        ps2DIn_cs = 1'b0;
        seen = 1'b1;
      end
    end
    check("coinc_push_seen", {7'd0, seen}, 8'h01);
    ps2DIn_cs = 1'b0;
    cyc(HALF);
    ps2Clk = 1'b1;
    cyc(20);
    check("coinc_stat", ps2StatInp, 8'h03);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("coinc_pop%0d", i), ps2kybdData, 8'h12 + 8'(i));
      popRead();
    end
    check("coinc_empty", ps2StatInp, 8'h00);

    // asynchronous reset mid-frame with a byte queued
    sendFrame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("prerst_data", ps2kybdData, 8'h3C);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_async_data", ps2kybdData, 8'h00);
    check("rst_async_stat", ps2StatInp, 8'h00);
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(50);
    check("rst_after_stat", ps2StatInp, 8'h00);
    sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("rst_recover_data", ps2kybdData, 8'hA5);
    check("rst_recover_stat", ps2StatInp, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
